// File: rtl/mc_ctrl.sv
// mc_ctrl: multicycle main control unit for the 32-bit MIPS-subset datapath.
// Moore FSM that sequences fetch/decode/execute/memory/writeback and decodes
// the latched opcode/funct into ALU operation, operand selects and enables.
//
// Ports:
//   clk, reset           clock (rising edge), async active-high reset
//   opcode, funct        IR[31:26], IR[5:0]
//   zero                 ALU zero flag (branch resolution)
//   mem_ready            memory completes the current access this cycle
//   ALUop                4-bit ALU operation code
//   alu_srca, alu_srcb   ALU operand selects
//   iord                 memory address select (0 PC, 1 ALUOut)
//   mem_read, mem_write  memory strobes
//   ir_we, reg_we        IR / register-file write enables
//   reg_dst, mem_to_reg  write register / write data selects
//   pc_we, pc_src        PC load enable and source select
//   state                current state encoding
//   illegal              sticky illegal-instruction flag
//
// Configuration macro: MC_CTRL_ILLEGAL_TRAP_EN
//   defined   : illegal opcode/funct traps into HALT until reset
//   undefined : illegal opcode/funct retires as a NOP back to FETCH
module mc_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic [3:0] ALUop,
  output logic [1:0] alu_srca,
  output logic [2:0] alu_srcb,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_we,
  output logic       reg_we,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       pc_we,
  output logic [1:0] pc_src,
  output logic [3:0] state,
  output logic       illegal
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_IEXEC  = 4'd10,
    S_IWB    = 4'd11,
    S_HALT   = 4'd12
  } state_e;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_AND = 4'b0100;
  localparam logic [3:0] ALU_SLT = 4'b0101;
  localparam logic [3:0] ALU_NOR = 4'b0110;
  localparam logic [3:0] ALU_SLL = 4'b0111;
  localparam logic [3:0] ALU_SRL = 4'b1000;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  state_e state_q, state_d;
  logic   illegal_q, illegal_d;

  logic       r_legal;
  logic       r_shift;
  logic [3:0] r_aluop;
  logic [3:0] i_aluop;
  logic       i_zext;

  // State and sticky illegal flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  // funct / immediate-opcode decode used by EXEC and IEXEC
  always_comb begin
    r_legal = 1'b1;
    r_shift = 1'b0;
    r_aluop = ALU_ADD;
    case (funct)
      6'b100000: r_aluop = ALU_ADD;
      6'b100010: r_aluop = ALU_SUB;
      6'b100100: r_aluop = ALU_AND;
      6'b100101: r_aluop = ALU_OR;
      6'b100111: r_aluop = ALU_NOR;
      6'b101010: r_aluop = ALU_SLT;
      6'b000000: begin r_aluop = ALU_SLL; r_shift = 1'b1; end
      6'b000010: begin r_aluop = ALU_SRL; r_shift = 1'b1; end
      default:   r_legal = 1'b0;
    endcase
    i_aluop = ALU_ADD;
    i_zext  = 1'b0;
    case (opcode)
      OP_SLTI: i_aluop = ALU_SLT;
      OP_ANDI: begin i_aluop = ALU_AND; i_zext = 1'b1; end
      OP_ORI:  begin i_aluop = ALU_OR;  i_zext = 1'b1; end
      default: i_aluop = ALU_ADD;
    endcase
  end

  // Next-state logic; illegal encodings trap or retire as NOP
  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    case (state_q)
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW:                      state_d = S_MEMADR;
          OP_RTYPE:                          state_d = S_EXEC;
          OP_BEQ, OP_BNE:                    state_d = S_BRANCH;
          OP_J:                              state_d = S_JUMP;
          OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: state_d = S_IEXEC;
          default: begin
            illegal_d = 1'b1;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
            state_d   = S_HALT;
`else
            state_d   = S_FETCH;
`endif
          end
        endcase
      end
      S_MEMADR: state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  if (mem_ready) state_d = S_FETCH;
      S_EXEC: begin
        if (r_legal) begin
          state_d = S_RWB;
        end else begin
          illegal_d = 1'b1;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
          state_d   = S_HALT;
`else
          state_d   = S_FETCH;
`endif
        end
      end
      S_RWB:    state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      S_IEXEC:  state_d = S_IWB;
      S_IWB:    state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_FETCH;
    endcase
  end

  // Moore output decode; ir_we/pc_we also see mem_ready (FETCH) and zero (BRANCH)
  always_comb begin
    ALUop      = ALU_ADD;
    alu_srca   = 2'b00;
    alu_srcb   = 3'b000;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_we      = 1'b0;
    reg_we     = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    pc_we      = 1'b0;
    pc_src     = 2'b00;
    case (state_q)
      S_FETCH: begin
        mem_read = 1'b1;
        alu_srcb = 3'b001;
        ir_we    = mem_ready;
        pc_we    = mem_ready;
      end
      S_DECODE: alu_srcb = 3'b011;
      S_MEMADR: begin
        alu_srca = 2'b01;
        alu_srcb = 3'b010;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      S_MEMWB: begin
        reg_we     = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      S_EXEC: begin
        if (r_legal) begin
          ALUop    = r_aluop;
          alu_srca = r_shift ? 2'b10 : 2'b01;
          alu_srcb = r_shift ? 3'b101 : 3'b000;
        end
      end
      S_RWB: begin
        reg_we  = 1'b1;
        reg_dst = 1'b1;
      end
      S_BRANCH: begin
        alu_srca = 2'b01;
        ALUop    = ALU_SUB;
        pc_src   = 2'b01;
        pc_we    = (opcode == OP_BEQ) ? zero : ~zero;
      end
      S_JUMP: begin
        pc_src = 2'b10;
        pc_we  = 1'b1;
      end
      S_IEXEC: begin
        alu_srca = 2'b01;
        ALUop    = i_aluop;
        alu_srcb = i_zext ? 3'b100 : 3'b010;
      end
      S_IWB: reg_we = 1'b1;
      default: ALUop = ALU_ADD;
    endcase
  end

  assign state   = state_q;
  assign illegal = illegal_q;

endmodule
